// File: rtl/btn_sw_pkg.sv
// btn_sw_pkg: shared colour/mode codes and button/switch bit indices.
package btn_sw_pkg;
    typedef enum logic [2:0] {
        COLOR_RED   = 3'b001,
        COLOR_GREEN = 3'b010,
        COLOR_BLUE  = 3'b100
    } color_e;
    typedef enum logic {
        MODE_SHIFT = 1'b0,
        MODE_FLASH = 1'b1
    } mode_e;
    localparam int BTN_MODE    = 0;
    localparam int BTN_RED     = 1;
    localparam int BTN_GREEN   = 2;
    localparam int BTN_BLUE    = 3;
    localparam int SW_ENABLE   = 0;
    localparam int SW_SPEED_LO = 1;
    localparam int SW_SPEED_HI = 2;
    localparam int SW_DIR      = 3;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: one button through a 2-flop synchronizer and debounce counter,
// emitting a registered one-cycle pulse when the debounced level rises.
module btn_debouncer #(
    parameter int NB_DEB     = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);
    localparam logic [NB_DEB-1:0] CNT_MAX = NB_DEB'(DEB_CYCLES - 1);
    logic [1:0]        sync_q;
    logic              stable_q, stable_d, prev_q, pulse_q;
    logic [NB_DEB-1:0] cnt_q, cnt_d;
    always_comb begin
        stable_d = (sync_q[1] != stable_q && cnt_q == CNT_MAX) ? sync_q[1] : stable_q;
        cnt_d    = (sync_q[1] == stable_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
    // prev_q delays stable by one edge so the pulse lands the edge after the flip
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], i_btn};
            stable_q <= stable_d;
            prev_q   <= stable_q;
            pulse_q  <= stable_q & ~prev_q;
            cnt_q    <= cnt_d;
        end
    end
    assign o_pulse = pulse_q;
endmodule

// File: rtl/btn_sw_decoder.sv
// btn_sw_decoder: synchronizes switches, debounces buttons and decodes both
// into registered mode/colour/enable/speed/direction commands.
module btn_sw_decoder
    import btn_sw_pkg::*;
#(
    parameter int NB_BUTTONS = 4,
    parameter int NB_SW      = 4,
    parameter int NB_DEB     = 16,
    parameter int DEB_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_BUTTONS-1:0] i_btn,
    input  logic [NB_SW-1:0]      i_sw,
    output logic [NB_BUTTONS-1:0] o_btn_pulse,
    output logic                  o_mode,
    output logic [2:0]            o_color,
    output logic                  o_enable,
    output logic [1:0]            o_speed,
    output logic                  o_dir,
    output logic                  o_cmd_valid
);
    logic [NB_SW-1:0] sw_s1_q, sw_s2_q;
    mode_e            mode_q, mode_d;
    color_e           color_q, color_d;
    logic             enable_q, enable_d, dir_q, dir_d, cmd_valid_q, cmd_valid_d;
    logic [1:0]       speed_q, speed_d;
    for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_deb
        btn_debouncer #(
            .NB_DEB    (NB_DEB),
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clock  (clock),
            .i_reset(i_reset),
            .i_btn  (i_btn[g]),
            .o_pulse(o_btn_pulse[g])
        );
    end
    always_comb begin
        mode_d      = o_btn_pulse[BTN_MODE] ? (mode_q == MODE_SHIFT ? MODE_FLASH : MODE_SHIFT) : mode_q;
        color_d     = o_btn_pulse[BTN_RED]   ? COLOR_RED   :
                      o_btn_pulse[BTN_GREEN] ? COLOR_GREEN :
                      o_btn_pulse[BTN_BLUE]  ? COLOR_BLUE  : color_q;
        enable_d    = sw_s2_q[SW_ENABLE];
        speed_d     = sw_s2_q[SW_SPEED_HI:SW_SPEED_LO];
        dir_d       = sw_s2_q[SW_DIR];
        // one flag covers any mix of button and switch changes landing together
        cmd_valid_d = {mode_d, color_d, enable_d, speed_d, dir_d} !=
                      {mode_q, color_q, enable_q, speed_q, dir_q};
    end
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            mode_q      <= MODE_SHIFT;
            color_q     <= COLOR_RED;
            enable_q    <= 1'b0;
            speed_q     <= 2'b00;
            dir_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
        end else begin
            sw_s1_q     <= i_sw;
            sw_s2_q     <= sw_s1_q;
            mode_q      <= mode_d;
            color_q     <= color_d;
            enable_q    <= enable_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end
    assign o_mode      = mode_q;
    assign o_color     = color_q;
    assign o_enable    = enable_q;
    assign o_speed     = speed_q;
    assign o_dir       = dir_q;
    assign o_cmd_valid = cmd_valid_q;
endmodule

// File: tb/tb_btn_sw_decoder.sv
// tb_btn_sw_decoder: directed stimulus with a cycle-stamped expectation queue
// checked by an independent monitor on the falling edge.
module tb_btn_sw_decoder;
    typedef struct {
        int          c;
        logic [12:0] v;
        string       n;
    } exp_t;
    logic       clock = 1'b0;
    logic       i_reset = 1'b1;
    logic [3:0] i_btn = 4'b0, i_sw = 4'b0;
    logic [3:0] o_btn_pulse;
    logic       o_mode, o_enable, o_dir, o_cmd_valid;
    logic [2:0] o_color;
    logic [1:0] o_speed;
    int         cyc = 0;
    int         total = 0, bad = 0;
    int         n;
    exp_t       q[$];
    exp_t       mon_e;
    logic [12:0] act;

    btn_sw_decoder #(.NB_BUTTONS(4), .NB_SW(4), .NB_DEB(16), .DEB_CYCLES(4)) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_btn      (i_btn),
        .i_sw       (i_sw),
        .o_btn_pulse(o_btn_pulse),
        .o_mode     (o_mode),
        .o_color    (o_color),
        .o_enable   (o_enable),
        .o_speed    (o_speed),
        .o_dir      (o_dir),
        .o_cmd_valid(o_cmd_valid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // expected vector = {pulse[3:0], cmd_valid, mode, color[2:0], enable, speed[1:0], dir}
    task automatic expect_at(input int c, input string nm, input logic [3:0] p, input logic cv,
                             input logic m, input logic [2:0] col, input logic en,
                             input logic [1:0] sp, input logic d);
        exp_t e;
        int   k;
        e.c = c;
        e.n = nm;
        e.v = {p, cv, m, col, en, sp, d};
        k = q.size();
        while (k > 0 && q[k-1].c > c) k--;
        q.insert(k, e);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap);
        i_btn = b;
        repeat (hold) @(negedge clock);
        i_btn = 4'b0;
        repeat (gap) @(negedge clock);
    endtask

    always @(negedge clock) begin
        act = {o_btn_pulse, o_cmd_valid, o_mode, o_color, o_enable, o_speed, o_dir};
        while (q.size() > 0 && q[0].c < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: no check at cycle %0d, want=%h", q[0].n, q[0].c, q[0].v);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            mon_e = q.pop_front();
            total++;
            if (act !== mon_e.v) begin
                bad++;
                $display("FAIL %s: cycle %0d got=%h want=%h", mon_e.n, cyc, act, mon_e.v);
            end
        end else if (act[12:8] != 5'b0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: cycle %0d got=%h want=no pulse/cmd_valid", cyc, act);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        expect_at(3, "rst_hold", 4'b0, 0, 0, 3'b001, 0, 2'b00, 0);
        repeat (10) @(negedge clock);
        i_reset = 1'b0;
        n = cyc;
        expect_at(n + 2,  "rst_release", 4'b0, 0, 0, 3'b001, 0, 2'b00, 0);
        expect_at(n + 20, "rst_idle",    4'b0, 0, 0, 3'b001, 0, 2'b00, 0);
        repeat (21) @(negedge clock);

        n = cyc;
        expect_at(n + 7, "green_pulse",  4'b0100, 0, 0, 3'b001, 0, 2'b00, 0);
        expect_at(n + 8, "green_cmd",    4'b0000, 1, 0, 3'b010, 0, 2'b00, 0);
        expect_at(n + 9, "green_settle", 4'b0000, 0, 0, 3'b010, 0, 2'b00, 0);
        press(4'b0100, 10, 15);

        n = cyc;
        i_reset = 1'b1;
        expect_at(n + 3, "rst_again", 4'b0, 0, 0, 3'b001, 0, 2'b00, 0);
        repeat (3) @(negedge clock);
        i_reset = 1'b0;
        repeat (3) @(negedge clock);

        n = cyc;
        expect_at(n + 7, "mode_red_pulse", 4'b0011, 0, 0, 3'b001, 0, 2'b00, 0);
        expect_at(n + 8, "mode_red_cmd",   4'b0000, 1, 1, 3'b001, 0, 2'b00, 0);
        press(4'b0011, 10, 15);

        n = cyc;
        expect_at(n + 7, "blue_pulse", 4'b1000, 0, 1, 3'b001, 0, 2'b00, 0);
        expect_at(n + 8, "blue_cmd",   4'b0000, 1, 1, 3'b100, 0, 2'b00, 0);
        press(4'b1000, 10, 15);

        n = cyc;
        expect_at(n + 15, "glitch_quiet", 4'b0, 0, 1, 3'b100, 0, 2'b00, 0);
        press(4'b1000, 3, 15);

        n = cyc;
        expect_at(n + 7, "blue_repeat_pulse", 4'b1000, 0, 1, 3'b100, 0, 2'b00, 0);
        expect_at(n + 8, "blue_repeat_nocmd", 4'b0000, 0, 1, 3'b100, 0, 2'b00, 0);
        press(4'b1000, 6, 15);

        n = cyc;
        i_sw = 4'b0001;
        expect_at(n + 2, "sw_enable_early", 4'b0, 0, 1, 3'b100, 0, 2'b00, 0);
        expect_at(n + 3, "sw_enable",       4'b0, 1, 1, 3'b100, 1, 2'b00, 0);
        repeat (6) @(negedge clock);
        n = cyc;
        i_sw = 4'b0011;
        expect_at(n + 3, "sw_speed1", 4'b0, 1, 1, 3'b100, 1, 2'b01, 0);
        repeat (6) @(negedge clock);
        n = cyc;
        i_sw = 4'b0101;
        expect_at(n + 3, "sw_speed2", 4'b0, 1, 1, 3'b100, 1, 2'b10, 0);
        repeat (6) @(negedge clock);
        n = cyc;
        i_sw = 4'b1111;
        expect_at(n + 3, "sw_speed3_dir", 4'b0, 1, 1, 3'b100, 1, 2'b11, 1);
        repeat (6) @(negedge clock);

        n = cyc;
        expect_at(n + 7, "combo_pulse", 4'b0100, 0, 1, 3'b100, 1, 2'b11, 1);
        expect_at(n + 8, "combo_cmd",   4'b0000, 1, 1, 3'b010, 1, 2'b11, 0);
        expect_at(n + 9, "combo_quiet", 4'b0000, 0, 1, 3'b010, 1, 2'b11, 0);
        i_btn = 4'b0100;
        repeat (5) @(negedge clock);
        i_sw = 4'b0111;
        repeat (5) @(negedge clock);
        i_btn = 4'b0;
        repeat (15) @(negedge clock);

        n = cyc;
        i_sw = 4'b0000;
        expect_at(n + 3, "sw_clear", 4'b0, 1, 1, 3'b010, 0, 2'b00, 0);
        repeat (6) @(negedge clock);

        n = cyc;
        expect_at(n + 5,  "rst_mid",         4'b0000, 0, 0, 3'b001, 0, 2'b00, 0);
        expect_at(n + 12, "red_after_rst",   4'b0010, 0, 0, 3'b001, 0, 2'b00, 0);
        expect_at(n + 13, "red_same_no_cmd", 4'b0000, 0, 0, 3'b001, 0, 2'b00, 0);
        i_btn = 4'b0010;
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        repeat (3) @(negedge clock);
        i_reset = 1'b0;
        repeat (10) @(negedge clock);
        i_btn = 4'b0;
        repeat (20) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
